vga_frame_ctrl: RTL
===================

# vga_frame_ctrl

Bus-mapped controller that configures the 640x480 VGA sync/pixel datapath from the Ibex device bus. Software writes shadow colour and enable registers at any time; the block commits them to the active outputs only at the start of vertical blanking, so a frame never changes mid-scan. It also counts frames and raises a vblank interrupt. It sits between the device bus and the VGA sync core, taking the core's pixel tick and counters and driving its colour and enable inputs.

## Interface
- CD, 12: colour depth; width of the colour registers and outputs.
- AddrWidth, 32: device bus address width.
- DataWidth, 32: device bus data width; must be at least 16.
- RegAddr, 12: number of low address bits decoded as the register offset.
- HD, 640: horizontal display width, in pixels.
- VD, 480: vertical display height, in lines; vblank starts at line VD.

- clk_i  in  1  system clock; one clock domain.
- rst_ni  in  1  reset, synchronous, active-low.
- device_req_i  in  1  bus request.
- device_addr_i  in  AddrWidth  byte address; offset is device_addr_i[RegAddr-1:0].
- device_we_i  in  1  1 = write.
- device_be_i  in  4  byte enables.
- device_wdata_i  in  DataWidth  write data.
- device_rvalid_o  out  1  response valid, one cycle after each request.
- device_rdata_o  out  DataWidth  read data, valid with rvalid.
- pix_tick_i  in  1  pixel-rate enable from the sync core.
- hc_i  in  11  horizontal count from the sync core.
- vc_i  in  11  vertical count from the sync core.
- fg_rgb_o  out  CD  active foreground colour.
- bg_rgb_o  out  CD  active background/border colour.
- video_en_o  out  1  active display enable; 0 forces the datapath to black.
- irq_o  out  1  level vblank interrupt, equal to irq_pending AND irq_en.

## Operation
- Register map (offset, access):
  - 0x00 CTRL (RW): bit0 enable; bit1 commit (write-1-to-set, reads as commit_pending, self-clears on commit); bit2 irq_en.
  - 0x04 FG (RW): shadow foreground colour in [CD-1:0].
  - 0x08 BG (RW): shadow background colour in [CD-1:0].
  - 0x0C STATUS: bit0 commit_pending (RO); bit1 irq_pending (write-1-to-clear); bit2 in_vblank (RO, combinational vc_i >= VD).
  - 0x10 FRAME_CNT (RO): 16-bit frame counter.
- Unmapped offsets read 0; writes to them are ignored.
- Byte-lane masking: a byte is written only when its device_be_i bit is 1. CTRL and STATUS use lane 0 only.
- Commit point: the cycle where pix_tick_i=1, hc_i=0 and vc_i=VD.
- At the commit point, if commit_pending=1: active enable/fg/bg are loaded from the shadow registers and commit_pending clears. If commit_pending=0, the active values hold.
- At every commit point, regardless of commit_pending: FRAME_CNT increments, wrapping 0xFFFF to 0x0000, and irq_pending sets.
- Shadow registers may be rewritten while a commit is pending; the last value written before the commit point is committed.
- Active-value state machine has two states: IDLE and PENDING.
  - IDLE -> PENDING on a CTRL write with bit1=1.
  - PENDING -> IDLE at the commit point.

## Timing
- Reset values: all registers and outputs are 0.
  - fg_rgb_o=0, bg_rgb_o=0, video_en_o=0, irq_o=0.
  - device_rvalid_o=0, device_rdata_o=0.
  - FRAME_CNT=0, all shadow registers 0, state IDLE.
- Bus handshake: every request is accepted in the cycle it is presented; there are no wait states.
  - device_rvalid_o=1 exactly one cycle later, for both reads and writes.
  - device_rdata_o is 0 for write responses.
  - Back-to-back requests give back-to-back rvalids.
- Register writes take effect on the clock edge that samples the request.
- Active outputs change on the clock edge ending the commit-point cycle. They are registered, so they are visible the following cycle.
- Simultaneous events:
  - A commit-bit write in the same cycle as the commit point: the commit proceeds with the pre-write shadow values, and commit_pending is left set by the new write (set wins).
  - An FG/BG write in the commit-point cycle: the old shadow value is committed; the new value waits for the next commit.
  - An irq_pending W1C in the same cycle as the commit point: irq_pending ends set (set wins).
- A reads of FRAME_CNT in the commit-point cycle returns the pre-increment value.
- Reset asserted mid-frame or with a commit pending returns every register and output to its reset value on the next edge. The pending commit is discarded.

## Test plan
- Reset: hold rst_ni=0 for 3 cycles while driving a bus write -> all outputs 0, no rvalid; after release, reading 0x0C returns 0x4 when vc_i>=480, otherwise 0x0.
- Deferred commit:
  - Stimulus: write FG=0xF00, BG=0x00F, CTRL=0x3 at vc_i=100.
  - Required: fg_rgb_o stays 0 until the commit point (vc_i=480, hc_i=0, tick), then fg_rgb_o=0xF00, bg_rgb_o=0x00F, video_en_o=1; CTRL then reads 0x1.
- Frame counter and IRQ:
  - Stimulus: set irq_en, run 3 frames.
  - Required: FRAME_CNT=3 and irq_o=1; write 0x2 to 0x0C gives irq_o=0 next cycle. W1C coinciding with the commit point leaves irq_o=1.
- Counter wrap: preload by running 65536 frames (or force) -> FRAME_CNT reads 0x0000 with no glitch on the other outputs.
- Byte masking: write FG with be=0x1 and wdata=0xABC over an FG of 0x123 -> shadow FG=0x1BC. Read of offset 0x20 returns 0; rvalid is asserted one cycle after every request, including back-to-back requests.
- Mid-operation reset: issue a commit, assert reset at vc_i=300 -> no commit occurs at the next vblank; all outputs stay 0.

Source files
------------

// File: rtl/vga_frame_ctrl.sv
// VGA frame controller: shadow colour/enable registers on the device bus, committed to the
// active outputs at the start of vertical blanking, plus a frame counter and vblank interrupt.
module vga_frame_ctrl #(
  parameter int unsigned CD        = 12,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RegAddr   = 12,
  parameter int unsigned HD        = 640,
  parameter int unsigned VD        = 480
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [DataWidth-1:0] device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [DataWidth-1:0] device_rdata_o,
  input  logic                 pix_tick_i,
  input  logic [10:0]          hc_i,
  input  logic [10:0]          vc_i,
  output logic [CD-1:0]        fg_rgb_o,
  output logic [CD-1:0]        bg_rgb_o,
  output logic                 video_en_o,
  output logic                 irq_o
);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  localparam logic [RegAddr-1:0] OffCtrl     = RegAddr'(8'h00);
  localparam logic [RegAddr-1:0] OffFg       = RegAddr'(8'h04);
  localparam logic [RegAddr-1:0] OffBg       = RegAddr'(8'h08);
  localparam logic [RegAddr-1:0] OffStatus   = RegAddr'(8'h0C);
  localparam logic [RegAddr-1:0] OffFrameCnt = RegAddr'(8'h10);
  localparam logic [10:0]        VdLine      = 11'(VD);

  state_e               state_q;
  logic                 en_sh_q;
  logic                 irq_en_q;
  logic                 irq_pending_q;
  logic [CD-1:0]        fg_sh_q;
  logic [CD-1:0]        bg_sh_q;
  logic [CD-1:0]        fg_q;
  logic [CD-1:0]        bg_q;
  logic                 video_en_q;
  logic [15:0]          frame_cnt_q;
  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q;
  logic [DataWidth-1:0] rdata_d;

  logic [RegAddr-1:0]   offset;
  logic [31:0]          be_mask;
  logic [CD-1:0]        lane_mask;
  logic [CD-1:0]        fg_sh_d;
  logic [CD-1:0]        bg_sh_d;
  logic                 wr;
  logic                 ctrl_wr;
  logic                 fg_wr;
  logic                 bg_wr;
  logic                 status_wr;
  logic                 commit_set;
  logic                 irq_clr;
  logic                 commit_pt;
  logic                 commit_pending;
  logic                 in_vblank;
  logic                 unused_bits;

  assign offset     = device_addr_i[RegAddr-1:0];
  assign be_mask    = {{8{device_be_i[3]}}, {8{device_be_i[2]}},
                       {8{device_be_i[1]}}, {8{device_be_i[0]}}};
  assign lane_mask  = be_mask[CD-1:0];

  assign wr         = device_req_i & device_we_i;
  assign ctrl_wr    = wr & device_be_i[0] & (offset == OffCtrl);
  assign status_wr  = wr & device_be_i[0] & (offset == OffStatus);
  assign fg_wr      = wr & (offset == OffFg);
  assign bg_wr      = wr & (offset == OffBg);
  assign commit_set = ctrl_wr & device_wdata_i[1];
  assign irq_clr    = status_wr & device_wdata_i[1];

  assign fg_sh_d = (fg_sh_q & ~lane_mask) | (device_wdata_i[CD-1:0] & lane_mask);
  assign bg_sh_d = (bg_sh_q & ~lane_mask) | (device_wdata_i[CD-1:0] & lane_mask);

  // First pixel of the first blanking line.
  assign commit_pt      = pix_tick_i & (hc_i == 11'd0) & (vc_i == VdLine);
  assign commit_pending = (state_q == StPending);
  assign in_vblank      = (vc_i >= VdLine);

  always_comb begin
    rdata_d = '0;
    if (device_req_i && !device_we_i) begin
      case (offset)
        OffCtrl:     rdata_d = DataWidth'({irq_en_q, commit_pending, en_sh_q});
        OffFg:       rdata_d = DataWidth'(fg_sh_q);
        OffBg:       rdata_d = DataWidth'(bg_sh_q);
        OffStatus:   rdata_d = DataWidth'({in_vblank, irq_pending_q, commit_pending});
        OffFrameCnt: rdata_d = DataWidth'(frame_cnt_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      en_sh_q       <= 1'b0;
      irq_en_q      <= 1'b0;
      irq_pending_q <= 1'b0;
      fg_sh_q       <= '0;
      bg_sh_q       <= '0;
      fg_q          <= '0;
      bg_q          <= '0;
      video_en_q    <= 1'b0;
      frame_cnt_q   <= '0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
    end else begin
      rvalid_q <= device_req_i;
      rdata_q  <= rdata_d;

      if (ctrl_wr) begin
        en_sh_q  <= device_wdata_i[0];
        irq_en_q <= device_wdata_i[2];
      end
      if (fg_wr) fg_sh_q <= fg_sh_d;
      if (bg_wr) bg_sh_q <= bg_sh_d;

      // A commit request arriving on the commit point re-arms for the next frame.
      unique case (state_q)
        StIdle: begin
          if (commit_set) state_q <= StPending;
        end
        StPending: begin
          if (commit_pt) begin
            fg_q       <= fg_sh_q;
            bg_q       <= bg_sh_q;
            video_en_q <= en_sh_q;
            if (!commit_set) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (commit_pt) begin
        frame_cnt_q   <= frame_cnt_q + 16'd1;
        irq_pending_q <= 1'b1;
      end else if (irq_clr) begin
        irq_pending_q <= 1'b0;
      end
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign fg_rgb_o        = fg_q;
  assign bg_rgb_o        = bg_q;
  assign video_en_o      = video_en_q;
  assign irq_o           = irq_pending_q & irq_en_q;

  assign unused_bits = ^{device_addr_i, device_wdata_i, device_be_i, be_mask, 11'(HD)};

endmodule
